// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts, load-op encodings and response FSM states for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_WD = 147;
  localparam int unsigned MEM_TO_WB_WD = 136;
  localparam int unsigned MEM_TO_ID_WD = 38;
  localparam int unsigned STALL_BUS    = 6;

  localparam int unsigned DATA_WD  = 32;
  localparam int unsigned MEMOP_WD = 5;
  localparam int unsigned WEN_WD   = 4;
  localparam int unsigned REG_AW   = 5;

  // One-hot mem_op bit positions
  localparam int unsigned MEMOP_LB  = 4;
  localparam int unsigned MEMOP_LBU = 3;
  localparam int unsigned MEMOP_LH  = 2;
  localparam int unsigned MEMOP_LHU = 1;
  localparam int unsigned MEMOP_LW  = 0;

  // Stall vector positions and polarity
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_DONE = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic               hi_we;
    logic               lo_we;
    logic [DATA_WD-1:0] hi;
    logic [DATA_WD-1:0] lo;
  } hilo_t;

  typedef struct packed {
    hilo_t               hilo;
    logic [MEMOP_WD-1:0] mem_op;
    logic [DATA_WD-1:0]  pc;
    logic                data_ram_en;
    logic [WEN_WD-1:0]   data_ram_wen;
    logic                sel_rf_res;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_WD-1:0]  ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic               rf_we;
    logic [REG_AW-1:0]  rf_waddr;
    logic [DATA_WD-1:0] rf_wdata;
  } mem_to_id_t;

  typedef struct packed {
    hilo_t              hilo;
    logic [DATA_WD-1:0] pc;
    logic               rf_we;
    logic [REG_AW-1:0]  rf_waddr;
    logic [DATA_WD-1:0] rf_wdata;
  } mem_to_wb_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a little-endian SRAM word and extends it to 32 bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [MEMOP_WD-1:0] mem_op,
  input  logic [1:0]          addr,
  input  logic [DATA_WD-1:0]  rdata,
  output logic [DATA_WD-1:0]  aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword ignores addr[0]; misalignment is not trapped here
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    aligned = rdata;
    if (mem_op[MEMOP_LB]) begin
      aligned = {{24{byte_sel[7]}}, byte_sel};
    end else if (mem_op[MEMOP_LBU]) begin
      aligned = {24'd0, byte_sel};
    end else if (mem_op[MEMOP_LH]) begin
      aligned = {{16{half_sel[15]}}, half_sel};
    end else if (mem_op[MEMOP_LHU]) begin
      aligned = {16'd0, half_sel};
    end else begin
      aligned = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX result, tracks the outstanding load response,
// aligns load data and drives the write-back / forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [DATA_WD-1:0]      data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    stall_for_mem
);

  ex_to_mem_t         stage_q;
  resp_state_e        state_q;
  resp_state_e        state_d;
  logic [DATA_WD-1:0] held_rdata;

  logic               reg_update;
  logic               is_load;
  logic               use_held;
  logic               latch_held;
  logic [DATA_WD-1:0] raw_rdata;
  logic [DATA_WD-1:0] aligned_rdata;
  logic [DATA_WD-1:0] rf_wdata;
  mem_to_wb_t         wb_out;
  mem_to_id_t         id_out;

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_BUS-1], stall[2:0]};

  // Register changes unless both EX and MEM are stopped (load, bubble or flush)
  assign reg_update = flush
                    | ~((stall[STALL_EX] == STOP) & (stall[STALL_MEM] == STOP));

  assign is_load = stage_q.data_ram_en
                 & (stage_q.data_ram_wen == WEN_WD'(0))
                 & (stage_q.mem_op != MEMOP_WD'(0));

  // Stage register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if ((stall[STALL_EX] == STOP) && (stall[STALL_MEM] == NO_STOP)) begin
      stage_q <= '0;
    end else if (stall[STALL_EX] == NO_STOP) begin
      stage_q <= ex_to_mem_t'(ex_to_mem_bus);
    end
  end

  // Response FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RESP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM next state; a register change always restarts in IDLE
  always_comb begin
    state_d = state_q;
    if (reg_update) begin
      state_d = RESP_IDLE;
    end else begin
      case (state_q)
        RESP_IDLE: begin
          if (is_load) begin
            state_d = data_sram_rvalid ? RESP_DONE : RESP_WAIT;
          end
        end
        RESP_WAIT: begin
          if (data_sram_rvalid) begin
            state_d = RESP_DONE;
          end
        end
        RESP_DONE: state_d = RESP_DONE;
        default:   state_d = RESP_IDLE;
      endcase
    end
  end

  // Response FSM outputs
  always_comb begin
    stall_for_mem = 1'b0;
    use_held      = 1'b0;
    latch_held    = 1'b0;
    case (state_q)
      RESP_IDLE, RESP_WAIT: begin
        stall_for_mem = is_load & ~data_sram_rvalid;
        latch_held    = is_load & data_sram_rvalid & ~reg_update;
      end
      RESP_DONE: use_held = 1'b1;
      default: begin
        stall_for_mem = 1'b0;
        use_held      = 1'b0;
        latch_held    = 1'b0;
      end
    endcase
  end

  // Captured response keeps a held load stable against later SRAM traffic
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_rdata <= '0;
    end else if (latch_held) begin
      held_rdata <= data_sram_rdata;
    end
  end

  assign raw_rdata = use_held ? held_rdata : data_sram_rdata;

  load_align u_load_align (
    .mem_op  (stage_q.mem_op),
    .addr    (stage_q.ex_result[1:0]),
    .rdata   (raw_rdata),
    .aligned (aligned_rdata)
  );

  assign rf_wdata = stage_q.sel_rf_res ? aligned_rdata : stage_q.ex_result;

  always_comb begin
    wb_out          = '0;
    wb_out.hilo     = stage_q.hilo;
    wb_out.pc       = stage_q.pc;
    wb_out.rf_we    = stage_q.rf_we;
    wb_out.rf_waddr = stage_q.rf_waddr;
    wb_out.rf_wdata = rf_wdata;

    id_out          = '0;
    id_out.rf_we    = stage_q.rf_we;
    id_out.rf_waddr = stage_q.rf_waddr;
    id_out.rf_wdata = rf_wdata;
  end

  assign mem_to_wb_bus = MEM_TO_WB_WD'(wb_out);
  assign mem_to_id_bus = MEM_TO_ID_WD'(id_out);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores with hand-computed results.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic [5:0]   stall;
  logic [146:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic         data_sram_rvalid;
  logic [135:0] mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;
  logic         stall_for_mem;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .stall            (stall),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_id_bus    (mem_to_id_bus),
    .stall_for_mem    (stall_for_mem)
  );

  typedef struct {
    int unsigned  cyc;
    string        name;
    bit           chk_bus;
    logic [135:0] wb;
    logic [37:0]  id;
    logic         st;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [5:0] HOLD = 6'b011111;
  localparam logic [4:0] OP_LB = 5'b10000, OP_LH = 5'b00100, OP_LHU = 5'b00010, OP_LW = 5'b00001;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [146:0] mk(input logic hi_we, input logic lo_we, input logic [31:0] hi,
                                      input logic [31:0] lo, input logic [4:0] op, input logic [31:0] pc,
                                      input logic en, input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] waddr, input logic [31:0] res);
    return {hi_we, lo_we, hi, lo, op, pc, en, wen, sel, we, waddr, res};
  endfunction

  function automatic logic [135:0] wb_of(input logic [146:0] b, input logic [31:0] wdata);
    return {b[146:81], b[75:44], b[37], b[36:32], wdata};
  endfunction

  function automatic logic [37:0] id_of(input logic [146:0] b, input logic [31:0] wdata);
    return {b[37], b[36:32], wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [146:0] b, input logic [31:0] d, input logic v,
                       input logic [5:0] s, input logic f);
    ex_to_mem_bus    = b;
    data_sram_rdata  = d;
    data_sram_rvalid = v;
    stall            = s;
    flush            = f;
  endtask

  task automatic expect_out(input string n, input bit cb, input logic [135:0] w,
                            input logic [37:0] i, input logic st);
    exp_t e;
    e.cyc = cyc; e.name = n; e.chk_bus = cb; e.wb = w; e.id = i; e.st = st;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (stall_for_mem !== e.st) begin
        errors++;
        $display("FAIL %s stall_for_mem: got %0b want %0b", e.name, stall_for_mem, e.st);
      end
      if (e.chk_bus) begin
        checks++;
        if (mem_to_wb_bus !== e.wb) begin
          errors++;
          $display("FAIL %s mem_to_wb_bus: got %h want %h", e.name, mem_to_wb_bus, e.wb);
        end
        checks++;
        if (mem_to_id_bus !== e.id) begin
          errors++;
          $display("FAIL %s mem_to_id_bus: got %h want %h", e.name, mem_to_id_bus, e.id);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [146:0] i_lb, i_lhu, i_lh, i_lw1, i_lw2, i_lw3, i_lw4, i_nl;
    int           budget;

    i_lb  = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LB,  32'h0000_0100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3,  32'h0000_1003);
    i_lhu = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LHU, 32'h0000_0104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,  32'h0000_2002);
    i_lh  = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LH,  32'h0000_0108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,  32'h0000_2000);
    i_lw1 = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LW,  32'h0000_010C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0000_3000);
    i_lw2 = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LW,  32'h0000_0110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h0000_3004);
    i_lw3 = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LW,  32'h0000_0114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_3008);
    i_lw4 = mk(1'b0, 1'b0, 32'h0, 32'h0, OP_LW,  32'h0000_0118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_300C);
    i_nl  = mk(1'b1, 1'b0, 32'h1111_2222, 32'h3333_4444, 5'b0, 32'hBFC0_0010,
               1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0000_0042);

    resetn = 1'b0;
    drive('0, 32'h0, 1'b0, 6'b0, 1'b0);
    tick(); tick();
    expect_out("reset", 1'b1, '0, '0, 1'b0);
    @(negedge clk); #1 resetn = 1'b1;

    tick(); drive(i_lb, 32'h0, 1'b0, 6'b0, 1'b0);
    tick(); drive(i_lhu, 32'h80AA_BBCC, 1'b1, 6'b0, 1'b0);
    expect_out("lb_sext", 1'b1, wb_of(i_lb, 32'hFFFF_FF80), id_of(i_lb, 32'hFFFF_FF80), 1'b0);
    tick(); drive(i_lh, 32'h8001_7FFF, 1'b1, 6'b0, 1'b0);
    expect_out("lhu_upper", 1'b1, wb_of(i_lhu, 32'h0000_8001), id_of(i_lhu, 32'h0000_8001), 1'b0);
    tick(); drive(i_lw1, 32'h8001_7FFF, 1'b1, 6'b0, 1'b0);
    expect_out("lh_lower", 1'b1, wb_of(i_lh, 32'h0000_7FFF), id_of(i_lh, 32'h0000_7FFF), 1'b0);

    // Delayed response: three stalled cycles then data
    tick(); drive(i_lw1, 32'h0, 1'b0, HOLD, 1'b0); expect_out("lw_wait0", 1'b0, '0, '0, 1'b1);
    tick(); drive(i_lw1, 32'h0, 1'b0, HOLD, 1'b0); expect_out("lw_wait1", 1'b0, '0, '0, 1'b1);
    tick(); drive(i_lw1, 32'h0, 1'b0, HOLD, 1'b0); expect_out("lw_wait2", 1'b0, '0, '0, 1'b1);
    tick(); drive(i_lw2, 32'h1234_5678, 1'b1, 6'b0, 1'b0);
    expect_out("lw_late", 1'b1, wb_of(i_lw1, 32'h1234_5678), id_of(i_lw1, 32'h1234_5678), 1'b0);

    // Response while held downstream, then SRAM data changes
    tick(); drive(i_lw2, 32'hCAFE_F00D, 1'b1, HOLD, 1'b0);
    expect_out("held0", 1'b1, wb_of(i_lw2, 32'hCAFE_F00D), id_of(i_lw2, 32'hCAFE_F00D), 1'b0);
    tick(); drive(i_lw2, 32'hDEAD_BEEF, 1'b0, HOLD, 1'b0);
    expect_out("held1", 1'b1, wb_of(i_lw2, 32'hCAFE_F00D), id_of(i_lw2, 32'hCAFE_F00D), 1'b0);
    tick(); drive(i_lw2, 32'hDEAD_BEEF, 1'b1, HOLD, 1'b0);
    expect_out("held2", 1'b1, wb_of(i_lw2, 32'hCAFE_F00D), id_of(i_lw2, 32'hCAFE_F00D), 1'b0);
    tick(); drive(i_lw3, 32'hDEAD_BEEF, 1'b0, 6'b0, 1'b0);
    expect_out("held3", 1'b1, wb_of(i_lw2, 32'hCAFE_F00D), id_of(i_lw2, 32'hCAFE_F00D), 1'b0);

    // Flush during WAIT, then a stray late response
    tick(); drive('0, 32'h0, 1'b0, HOLD, 1'b0); expect_out("flush_wait0", 1'b0, '0, '0, 1'b1);
    tick(); drive('0, 32'h0, 1'b0, HOLD, 1'b1); expect_out("flush_wait1", 1'b0, '0, '0, 1'b1);
    tick(); drive(i_nl, 32'h55AA_55AA, 1'b1, 6'b0, 1'b0);
    expect_out("flush_zero", 1'b1, '0, '0, 1'b0);

    // Non-load pass-through with hilo fields
    tick(); drive(i_lw4, 32'h0, 1'b0, 6'b0, 1'b0);
    expect_out("nonload", 1'b1,
               {1'b1, 1'b0, 32'h1111_2222, 32'h3333_4444, 32'hBFC0_0010, 1'b1, 5'd5, 32'h0000_0042},
               {1'b1, 5'd5, 32'h0000_0042}, 1'b0);

    // Asynchronous reset in the middle of WAIT
    tick(); drive('0, 32'h0, 1'b0, HOLD, 1'b0); expect_out("rst_wait0", 1'b0, '0, '0, 1'b1);
    tick(); drive('0, 32'h0, 1'b0, HOLD, 1'b0); expect_out("rst_wait1", 1'b0, '0, '0, 1'b1);
    tick(); resetn = 1'b0;
    expect_out("async_reset", 1'b1, '0, '0, 1'b0);
    @(negedge clk); #1 resetn = 1'b1;
    tick(); drive('0, 32'h0, 1'b0, 6'b0, 1'b0);
    expect_out("post_reset", 1'b1, '0, '0, 1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      errors++;
      $display("FAIL %s: expectation left unchecked after cycle budget", e.name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage. Sits directly after the execute stage and before write-back. It registers the execute stage's result bus and waits for load data from the data SRAM via a response handshake. It aligns and extends the loaded byte/half/word, selects the register write-back value, and forwards it to ID and WB. While a load's data is outstanding it requests a pipeline stall, and it keeps data that arrives while the stage is held.

## Interface
Parameters: none. Widths come from `lib/defines.vh`: `EX_TO_MEM_WD`=147, `MEM_TO_WB_WD`=136, `MEM_TO_ID_WD`=38, `StallBus`=6.

Ports:
- `clk` in 1: sole clock. All state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: clears the stage register, synchronous.
- `stall` in `StallBus`: per-stage stop vector. `stall[3]` gates the EX→MEM register; `stall[4]` is MEM's downstream.
- `ex_to_mem_bus` in 147. Fields:
  - hilo_bus [146:81] = {hi_we, lo_we, hi[31:0], lo[31:0]}
  - mem_op [80:76] = one-hot {lb, lbu, lh, lhu, lw}
  - pc [75:44], data_ram_en [43], data_ram_wen [42:39]
  - sel_rf_res [38], rf_we [37], rf_waddr [36:32], ex_result [31:0] (also the memory address)
- `data_sram_rdata` in 32: load data from the data SRAM.
- `data_sram_rvalid` in 1: single-cycle strobe; `data_sram_rdata` is valid this cycle.
- `mem_to_wb_bus` out 136: {hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- `mem_to_id_bus` out 38: {rf_we, rf_waddr, rf_wdata}, used for forwarding.
- `stall_for_mem` out 1: stall request to the stall controller.

## Operation
Stage register, priority order:
1. `resetn` low → 0.
2. Else `flush` → 0.
3. Else `stall[3]`=Stop and `stall[4]`=NoStop → 0 (bubble).
4. Else `stall[3]`=NoStop → load `ex_to_mem_bus`.
5. Otherwise hold.

Load instruction: `is_load` = data_ram_en & (data_ram_wen==0) & (mem_op!=0). Stores pass through; the write already happened in EX.

Response FSM, 3 states. Reset, flush and every register load force IDLE.
- IDLE, no pending load. If `is_load`:
  - `rvalid`=1 → data used combinationally. If the register holds, latch it and go to DONE.
  - `rvalid`=0 → go to WAIT.
- WAIT: `stall_for_mem`=1 until `rvalid`. On `rvalid`, use the data combinationally, latch it into `held_rdata` and go to DONE.
- DONE: `stall_for_mem`=0. The load uses `held_rdata`; any further `rvalid` is ignored. Exit to IDLE when the register loads a new instruction.
- Register-load transitions take priority over response transitions.

Outputs:
- `stall_for_mem` = is_load & (state≠DONE) & ~rvalid.
- Raw data = DONE ? `held_rdata` : `data_sram_rdata`.

Alignment, with a = ex_result[1:0]:
- lb / lbu: byte a, sign- or zero-extended to 32 bits.
- lh / lhu: half selected by a[1] (a[0] ignored; no address exception), sign- or zero-extended.
- lw: the full word.
- Little-endian: byte 0 = bits [7:0].

`rf_wdata` = sel_rf_res ? aligned load data : ex_result. hilo_bus and pc pass through unchanged.

## Timing
- Non-load: combinational pass-through. The result reaches WB/ID the same cycle it enters MEM.
- Fixed-latency SRAM: `rvalid` arrives the cycle the load is in MEM. No stall; zero added latency.
- Delayed response: `stall_for_mem` is high from the first MEM cycle through the cycle before `rvalid`. The cycle `rvalid` is high, `stall_for_mem` drops and `rf_wdata` is valid.
- `rvalid` while the stage is held by `stall[4]` → data latched. It is presented from DONE on every following cycle until the instruction leaves.
- Flush during WAIT → register 0, IDLE, `stall_for_mem`=0 the next cycle. A late `rvalid` in IDLE with no load is ignored.
- Reset mid-WAIT (asynchronous) → register 0, IDLE, `held_rdata`=0 immediately.
- Reset values: all outputs 0 (the bus is all-zero, so rf_we=0), `stall_for_mem`=0.

## Structure
- `lib/defines.vh` gains `MEM_TO_WB_WD`, `MEM_TO_ID_WD`, mem_op bit indices (`MEMOP_LB`=4 … `MEMOP_LW`=0) and the FSM state encodings. Stop/NoStop already exist there.
- One combinational sub-module, `load_align` (ports: mem_op, addr[1:0], rdata → aligned data). The stage register, FSM and muxes stay in `mem_stage`.

## Test plan
- lb at addr 0x…03, rdata=0x80AA_BBCC, `rvalid` same cycle → rf_wdata=0xFFFF_FF80, stall_for_mem never 1.
- lhu at addr 0x…02, rdata=0x8001_7FFF; lh at addr 0x…00, same data → 0x0000_8001 and 0x0000_7FFF respectively.
- lw, `rvalid` 3 cycles late (rdata=0x1234_5678) → stall_for_mem=1 for exactly 3 cycles, then rf_wdata=0x1234_5678 with stall_for_mem=0.
- lw with `rvalid` while `stall[4]`=Stop for 2 cycles, rdata changing to 0xDEAD_BEEF afterwards → held value (0xCAFE_F00D) presented on both cycles.
- Flush during WAIT, then a late `rvalid` → bus all zero, stall_for_mem=0, no write (rf_we=0).
- Non-load (sel_rf_res=0, ex_result=0x0000_0042, rf_waddr=5, hi_we=1) → mem_to_id_bus={1,5,0x42}, hilo fields unchanged in mem_to_wb_bus.
